// File: rtl/dds_pkg.sv
// Shared DDS definitions: sample width, midscale code and the signed to
// offset-binary conversion used by both the sine generator and the PWM stage.
package dds_pkg;

  localparam int MAG_WIDTH = 8;
  localparam logic [MAG_WIDTH-1:0] MIDSCALE = {1'b1, {(MAG_WIDTH-1){1'b0}}};

  // Two's complement to offset binary: flipping the sign bit maps the most
  // negative code to 0 and signal zero to midscale.
  function automatic logic [MAG_WIDTH-1:0] to_offset_binary(input logic [MAG_WIDTH-1:0] s);
    return {~s[MAG_WIDTH-1], s[MAG_WIDTH-2:0]};
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Tick generator: one tick every PRESCALE enabled clocks. The count freezes
// while en is low so a paused PWM resumes exactly where it stopped.
module pwm_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;

  // With PRESCALE=1 LAST is 0, pre never leaves 0 and tick simply follows en.
  assign tick = en & (pre == LAST);

  // Prescale counter, wraps after LAST, held while disabled.
  always_ff @(posedge clk) begin
    if (rst)
      pre <= '0;
    else if (en)
      pre <= (pre == LAST) ? '0 : pre + 1'b1;
  end

endmodule

// File: rtl/pwm_dac.sv
// PWM output stage: double-buffered sample intake over valid/ready, one PWM
// period of 2^MAG_WIDTH ticks per sample, sticky underrun when a period has
// to repeat the previous duty.
module pwm_dac #(
  parameter int MAG_WIDTH = dds_pkg::MAG_WIDTH,
  parameter int PRESCALE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [MAG_WIDTH-1:0] sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  input  logic                 clr_underrun,
  output logic                 pwm_out,
  output logic                 period_start,
  output logic                 underrun
);

  localparam logic [MAG_WIDTH-1:0] MID     = {1'b1, {(MAG_WIDTH-1){1'b0}}};
  localparam logic [MAG_WIDTH-1:0] CNT_MAX = '1;

  logic                 tick;
  logic                 hold_full;
  logic                 xfer;
  logic                 load;
  logic [MAG_WIDTH-1:0] duty_in;
  logic [MAG_WIDTH-1:0] hold;
  logic [MAG_WIDTH-1:0] active_duty;
  logic [MAG_WIDTH-1:0] cnt;

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // Reuse the shared conversion when widths line up; otherwise flip the MSB directly.
  if (MAG_WIDTH == dds_pkg::MAG_WIDTH) begin : g_conv_pkg
    assign duty_in = dds_pkg::to_offset_binary(sample_in);
  end else begin : g_conv_gen
    assign duty_in = sample_in ^ MID;
  end

  assign sample_ready = ~hold_full;
  assign xfer         = sample_valid & ~hold_full;
  // Load event: last tick of the period.
  assign load         = tick & (cnt == CNT_MAX);

  // Period counter, wraps naturally at 2^MAG_WIDTH.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (tick)
      cnt <= cnt + 1'b1;
  end

  // Hold/active double buffer. On a load event an empty hold lets a sample
  // arriving that same cycle go straight to the active register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold        <= '0;
      hold_full   <= 1'b0;
      active_duty <= MID;
    end else if (load) begin
      if (hold_full) begin
        active_duty <= hold;
        hold_full   <= 1'b0;
      end else if (xfer) begin
        active_duty <= duty_in;
      end
    end else if (xfer) begin
      hold      <= duty_in;
      hold_full <= 1'b1;
    end
  end

  // Registered pin, period marker and sticky underrun (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      pwm_out      <= en & (cnt < active_duty);
      period_start <= load;
      if (load & ~hold_full & ~xfer)
        underrun <= 1'b1;
      else if (clr_underrun)
        underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac: scoreboard of per-period high times plus directed
// sequences for bypass, back-pressure, pause and flag corner cases.
module tb_pwm_dac;

  logic       clk;
  logic       rst, en, valid, clr;
  logic [7:0] sample;
  logic       ready, pwm, ps, ur;
  logic       rst4, en4, valid4, clr4;
  logic [7:0] sample4;
  logic       ready4, pwm4, ps4, ur4;

  pwm_dac #(.MAG_WIDTH(8), .PRESCALE(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .sample_in(sample), .sample_valid(valid),
    .sample_ready(ready), .clr_underrun(clr), .pwm_out(pwm),
    .period_start(ps), .underrun(ur)
  );

  pwm_dac #(.MAG_WIDTH(8), .PRESCALE(4)) u_dut4 (
    .clk(clk), .rst(rst4), .en(en4), .sample_in(sample4), .sample_valid(valid4),
    .sample_ready(ready4), .clr_underrun(clr4), .pwm_out(pwm4),
    .period_start(ps4), .underrun(ur4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: expected high count tagged with the period index it belongs to.
  typedef struct { int p; int high; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   pidx;
  int   acc;

  // Monitor: accumulate high cycles, report at each period_start. The pwm bit
  // seen on the period_start cycle still belongs to the finished period.
  always @(negedge clk) begin
    if (rst) begin
      acc  = 0;
      pidx = 0;
    end else begin
      acc += int'(pwm);
      if (ps) begin
        if (exp_q.size() > 0) begin
          if (exp_q[0].p == pidx) begin
            mon_e = exp_q.pop_front();
            check($sformatf("period%0d_high", pidx), acc, mon_e.high);
          end else if (exp_q[0].p < pidx) begin
            mon_e = exp_q.pop_front();
            check("period_missed", pidx, mon_e.p);
          end
        end
        acc = 0;
        pidx++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!ps && n < 2000);
    if (!ps) check("ps_timeout", 0, 1);
  endtask

  task automatic push_exp(input int p, input int high);
    exp_t e;
    e.p    = p;
    e.high = high;
    exp_q.push_back(e);
  endtask

  // Offer one sample and hold it until accepted; reports the period and the
  // period_start value of the accepting cycle.
  task automatic send(input logic [7:0] s, output int p_acc, output logic ps_acc);
    int   k;
    logic a;
    sample = s;
    valid  = 1'b1;
    k      = 0;
    do begin
      a      = ready;
      p_acc  = pidx;
      ps_acc = ps;
      step();
      k++;
    end while (!a && k < 1000);
    valid = 1'b0;
    if (!a) check("send_timeout", 0, 1);
  endtask

  typedef struct { logic [7:0] s; int high; logic ur; } vec_t;
  vec_t vecs[5];

  initial begin
    int   n, hi, p, r;
    logic pa;

    vecs[0] = '{8'h80, 0,   1'b0};
    vecs[1] = '{8'h00, 128, 1'b0};
    vecs[2] = '{8'h7F, 255, 1'b0};
    vecs[3] = '{8'hC0, 64,  1'b0};
    vecs[4] = '{8'h01, 129, 1'b0};

    rst = 1'b1; en = 1'b0; valid = 1'b0; clr = 1'b0; sample = '0;
    rst4 = 1'b1; en4 = 1'b0; valid4 = 1'b0; clr4 = 1'b0; sample4 = '0;
    repeat (3) step();
    check("rst_ready", int'(ready), 1);
    check("rst_pwm",   int'(pwm),   0);
    check("rst_ps",    int'(ps),    0);
    check("rst_ur",    int'(ur),    0);

    // Free-running midscale with no samples.
    push_exp(0, 128); push_exp(1, 128); push_exp(2, 128);
    rst = 1'b0; en = 1'b1;
    wait_ps(n);
    check("first_period_len", n, 256);
    check("ur_after_first_load", int'(ur), 1);
    wait_ps(n);
    check("period1_len", n, 256);
    wait_ps(n);
    check("period2_len", n, 256);

    // Table: one sample per period.
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_ur", int'(ur), 0);
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].s, p, pa);
      push_exp(p + 1, vecs[i].high);
      wait_ps(n);
      check($sformatf("vec%0d_ur", i), int'(ur), int'(vecs[i].ur));
    end
    wait_ps(n);

    // Bypass: sample offered on the load-event cycle with the hold empty.
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t3_clr_ur", int'(ur), 0);
    repeat (254) step();
    check("t3_ready_at_load", int'(ready), 1);
    send(8'h40, p, pa);
    push_exp(p + 1, 192);
    check("t3_ps", int'(ps), 1);
    check("t3_ur", int'(ur), 0);
    check("t3_ready_after", int'(ready), 1);

    // Back-to-back samples: second waits for the load event.
    send(8'h20, p, pa);
    push_exp(p + 1, 160);
    sample = 8'hE0;
    valid  = 1'b1;
    check("t4_ready_blocked", int'(ready), 0);
    send(8'hE0, r, pa);
    check("t4_second_on_period_start", int'(pa), 1);
    check("t4_second_period", r, p + 1);
    push_exp(r + 1, 96);
    wait_ps(n);
    wait_ps(n);

    // Pause 50 cycles mid-period; duty 96 repeats (underrun period).
    push_exp(pidx, 96);
    repeat (40) step();
    en = 1'b0;
    hi = 0;
    repeat (50) begin
      step();
      hi += int'(pwm);
    end
    en = 1'b1;
    check("t6_pwm_low_while_paused", hi, 0);
    wait_ps(n);
    check("t6_remaining_ticks", n, 216);

    // Clear and underrun event on the same cycle: set wins.
    push_exp(pidx, 96);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t6_clr_ur", int'(ur), 0);
    repeat (254) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t6_set_wins_ps", int'(ps), 1);
    check("t6_set_wins_ur", int'(ur), 1);
    step();

    // PRESCALE=4: 1024-cycle period, duty 64 -> 256 high cycles.
    rst4 = 1'b0; en4 = 1'b1; valid4 = 1'b1; sample4 = 8'hC0;
    n = 0; hi = 0;
    do begin
      step();
      valid4 = 1'b0;
      n++;
      hi += int'(pwm4);
    end while (!ps4 && n < 3000);
    check("p4_first_len", n, 1024);
    check("p4_first_high", hi, 512);
    check("p4_ur", int'(ur4), 0);
    n = 0; hi = 0;
    do begin
      step();
      n++;
      hi += int'(pwm4);
    end while (!ps4 && n < 3000);
    check("p4_len", n, 1024);
    check("p4_high", hi, 256);

    step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
